// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed FIFO controller: classification of what
// happens to the occupancy on a given clock edge.
package ram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_PUSH = 2'b01,
    XFER_POP  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic xfer_e xfer_kind(input logic push, input logic pop);
    return xfer_e'({pop, push});
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_dual_port_ram.sv
// Simple dual-port RAM: synchronous write, registered read address.
// A write and a read of the same address on one edge returns the new word.
module dual_port_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller around a dual-port RAM; holds pointers,
// occupancy and flags. Contents survive reset/flush, only pointers clear.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = AFULL_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  push;
  logic                  pop;
  logic                  we;

  // Flags depend only on registered occupancy, never on in_valid/out_ready.
  assign in_ready    = (count_q != DEPTH_CNT);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AFULL_CNT);
  assign count       = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign we   = push && !reset && !flush;

  // Look one entry ahead on a pop so the new head is visible next cycle.
  always_comb begin
    rd_addr = rd_ptr;
    if (reset || flush) rd_addr = '0;
    else if (pop)       rd_addr = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (xfer_kind(push, pop))
        XFER_PUSH: count_q <= count_q + 1'b1;
        XFER_POP:  count_q <= count_q - 1'b1;
        default:   count_q <= count_q;
      endcase
    end
  end

  dual_port_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

endmodule
